// File: rtl/mont_pkg.sv
// Shared types for the Montgomery exponentiation controller and its multiplier.
package mont_pkg;

    localparam int LEN_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        CONV_B,
        CONV_A,
        SQR,
        MUL,
        FROM_M,
        DONE
    } state_t;

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Request/response bundle between a caller and mont_exp_ctrl.
import mont_pkg::*;

interface mont_exp_ctrl_if #(parameter int LEN = LEN_DEFAULT);
    logic           start;
    logic [LEN-1:0] base;
    logic [LEN-1:0] exp;
    logic [LEN-1:0] n;
    logic [LEN-1:0] n_prime;
    logic [LEN-1:0] r2;
    logic           busy;
    logic           done;
    logic [LEN-1:0] result;

    modport master (
        output start, base, exp, n, n_prime, r2,
        input  busy, done, result
    );

    modport slave (
        input  start, base, exp, n, n_prime, r2,
        output busy, done, result
    );
endinterface

// File: rtl/mont_mul.sv
// Combinational Montgomery product p = a*b*R^-1 mod n, R = 2^LEN, for a,b < n.
import mont_pkg::*;

module mont_mul #(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic [LEN-1:0] n,
    input  logic [LEN-1:0] n_prime,
    output logic [LEN-1:0] p
);

    logic [2*LEN-1:0] t;
    logic [LEN-1:0]   m;
    logic [2*LEN:0]   u;
    logic [LEN:0]     s;
    logic [LEN:0]     d;

    always_comb begin
        t = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
        m = t[LEN-1:0] * n_prime;
        u = {1'b0, t} + ({{(LEN+1){1'b0}}, m} * {{(LEN+1){1'b0}}, n});
        s = (LEN+1)'(u >> LEN);
        // s < 2n, so the top bit of s - n is exactly the borrow.
        d = s - {1'b0, n};
        p = d[LEN] ? s[LEN-1:0] : d[LEN-1:0];
    end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right Montgomery modular exponentiation sequencer around one mont_mul.
// Optional build macro MONT_EXP_CONST_TIME_EN: issue a multiply for every exponent bit.
import mont_pkg::*;

module mont_exp_ctrl #(
    parameter int LEN = LEN_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    mont_exp_ctrl_if.slave  bus
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

    state_t         state, next_state;
    logic [LEN-1:0] base_q, exp_q, n_q, np_q, r2_q;
    logic [LEN-1:0] bm, acc, result_q;
    logic [IW-1:0]  idx;
    logic [LEN-1:0] mm_a, mm_b, mm_p;

    mont_mul #(.LEN(LEN)) u_mul (
        .a       (mm_a),
        .b       (mm_b),
        .n       (n_q),
        .n_prime (np_q),
        .p       (mm_p)
    );

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        next_state = state;
        mm_a       = '0;
        mm_b       = '0;
        case (state)
            IDLE:   if (bus.start) next_state = CONV_B;
            CONV_B: begin
                mm_a       = base_q;
                mm_b       = r2_q;
                next_state = CONV_A;
            end
            CONV_A: begin
                mm_a       = r2_q;
                mm_b       = LEN'(1);
                next_state = SQR;
            end
            SQR: begin
                mm_a = acc;
                mm_b = acc;
`ifdef MONT_EXP_CONST_TIME_EN
                next_state = MUL;
`else
                if (exp_q[idx])      next_state = MUL;
                else if (idx == '0)  next_state = FROM_M;
                else                 next_state = SQR;
`endif
            end
            MUL: begin
                mm_a       = acc;
                mm_b       = bm;
                next_state = (idx == '0) ? FROM_M : SQR;
            end
            FROM_M: begin
                mm_a       = acc;
                mm_b       = LEN'(1);
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            np_q     <= '0;
            r2_q     <= '0;
            bm       <= '0;
            acc      <= '0;
            result_q <= '0;
            idx      <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (bus.start) begin
                    base_q <= bus.base;
                    exp_q  <= bus.exp;
                    n_q    <= bus.n;
                    np_q   <= bus.n_prime;
                    r2_q   <= bus.r2;
                end
                CONV_B: bm <= mm_p;
                CONV_A: begin
                    acc <= mm_p;
                    idx <= IW'(LEN - 1);
                end
                SQR: begin
                    acc <= mm_p;
                    if (next_state == SQR) idx <= idx - 1'b1;
                end
                MUL: begin
                    // Dummy multiply for zero bits in the constant-time build.
                    if (exp_q[idx]) acc <= mm_p;
                    if (next_state == SQR) idx <= idx - 1'b1;
                end
                FROM_M:  result_q <= mm_p;
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE) && (state != DONE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench: directed LEN=8 cases plus randomized LEN=256 vectors vs plain modexp.
module tb_mont_exp_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mont_exp_ctrl_if #(.LEN(8))   if8 ();
    mont_exp_ctrl_if #(.LEN(256)) if256 ();

    mont_exp_ctrl #(.LEN(8))   dut8   (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    mont_exp_ctrl #(.LEN(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256.slave));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] ref_modexp(input logic [255:0] x, input logic [255:0] e,
                                               input logic [255:0] m);
        logic [511:0] r, xm, mm;
        xm = {256'b0, x};
        mm = {256'b0, m};
        r  = 512'd1 % mm;
        for (int i = 255; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * xm) % mm;
        end
        return r[255:0];
    endfunction

    function automatic int exp_lat(input int len, input logic [255:0] e);
`ifdef MONT_EXP_CONST_TIME_EN
        return 3 + 2 * len;
`else
        return 3 + len + $countones(e);
`endif
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r = {r[223:0], $urandom};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one LEN=8 job; optionally re-pulses start mid-run (poke >= 0) and in the DONE cycle.
    task automatic run8(input logic [7:0] x, input logic [7:0] e, input int poke, input string tag);
        int cyc;
        logic [255:0] want;
        want = ref_modexp({248'b0, x}, {248'b0, e}, 256'd13);
        if8.base = x; if8.exp = e; if8.n = 8'h0D; if8.n_prime = 8'h3B; if8.r2 = 8'h03;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        if8.base = ~x; if8.exp = ~e; if8.r2 = 8'h55;
        check({tag, " busy_after_start"}, 256'(if8.busy), 256'd1);
        cyc = 0;
        while (!if8.done && cyc < 200) begin
            if (cyc == poke) begin
                if8.start = 1'b1; if8.base = 8'h04; if8.exp = 8'h0D;
            end
            tick();
            if8.start = 1'b0;
            cyc++;
            if (!if8.done) check({tag, " busy_during_run"}, 256'(if8.busy), 256'd1);
        end
        check({tag, " latency"}, 256'(cyc), 256'(exp_lat(8, {248'b0, e})));
        check({tag, " busy_done_exclusive"}, 256'(if8.busy & if8.done), 256'd0);
        check({tag, " result"}, {248'b0, if8.result}, want);
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        check({tag, " done_single_cycle"}, 256'(if8.done), 256'd0);
        check({tag, " start_in_done_ignored"}, 256'(if8.busy), 256'd0);
        tick();
        check({tag, " idle_after_done"}, 256'(if8.busy), 256'd0);
        check({tag, " result_held"}, {248'b0, if8.result}, want);
    endtask

    initial begin
        logic [255:0] n, x, e, inv, np, r2, want;
        logic [512:0] big;
        int cyc;

        if8.start = 1'b0; if8.base = '0; if8.exp = '0; if8.n = '0; if8.n_prime = '0; if8.r2 = '0;
        if256.start = 1'b0; if256.base = '0; if256.exp = '0; if256.n = '0;
        if256.n_prime = '0; if256.r2 = '0;

        #1;
        check("reset busy", 256'(if8.busy), 256'd0);
        check("reset done", 256'(if8.done), 256'd0);
        check("reset result", {248'b0, if8.result}, 256'd0);
        #22;
        rst_n = 1'b1;
        tick();

        run8(8'd4, 8'd13, -1, "x4e13");
        run8(8'd2, 8'd5, -1, "x2e5");
        run8(8'd7, 8'd0, -1, "x7e0");
        run8(8'd0, 8'd9, -1, "x0e9");
        run8(8'd2, 8'd5, 4, "restart_ignored");
        run8(8'd12, 8'd255, -1, "x12e255");

        // Abort mid-run: reset lands asynchronously while squaring.
        if8.base = 8'd2; if8.exp = 8'd5; if8.n = 8'h0D; if8.n_prime = 8'h3B; if8.r2 = 8'h03;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 256'(if8.busy), 256'd0);
        check("abort done", 256'(if8.done), 256'd0);
        check("abort result", {248'b0, if8.result}, 256'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort no_done", 256'(if8.done), 256'd0);
        end
        #3;
        rst_n = 1'b1;
        tick();
        run8(8'd2, 8'd5, -1, "after_abort");

        for (int v = 0; v < 100; v++) begin
            n = rand256();
            n[255] = 1'b1;
            n[0]   = 1'b1;
            x = rand256() % n;
            e = rand256();
            inv = n;
            for (int k = 0; k < 8; k++) inv = inv * (256'd2 - n * inv);
            np = -inv;
            big = '0;
            big[512] = 1'b1;
            big = big % {257'b0, n};
            r2 = big[255:0];
            want = ref_modexp(x, e, n);

            if256.base = x; if256.exp = e; if256.n = n; if256.n_prime = np; if256.r2 = r2;
            if256.start = 1'b1;
            tick();
            if256.start = 1'b0;
            cyc = 0;
            while (!if256.done && cyc < 700) begin
                tick();
                cyc++;
            end
            check($sformatf("rand%0d latency", v), 256'(cyc), 256'(exp_lat(256, e)));
            check($sformatf("rand%0d result", v), if256.result, want);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
